// File: rtl/bod_pkg.sv
// ---------------------------------------------------------------------------
// bod_pkg
// Shared definitions for the brownout threshold detector: the per-channel
// level FSM state encoding, the debounce counter width, and a helper that
// decodes which states present an asserted flag.
// ---------------------------------------------------------------------------
package bod_pkg;

  // Debounce counter width; large enough for a debounce count of 255.
  localparam int BOD_CNT_W = 8;

  typedef enum logic [1:0] {
    CLEAR,
    PEND_SET,
    SET,
    PEND_CLR
  } bod_state_t;

  // The flag stays up while a release is still being debounced.
  function automatic logic is_flag_state(input bod_state_t s);
    return (s == SET) || (s == PEND_CLR);
  endfunction

endpackage

// File: rtl/bod_level_fsm.sv
// ---------------------------------------------------------------------------
// bod_level_fsm
// One threshold channel of the brownout detector. Trips when the sample
// falls below 'th', releases when the sample climbs to 'th + hyst' or above,
// and requires DEBOUNCE consecutive valid samples in either direction before
// the flag changes. Samples between the two levels are neutral: they hold the
// state and discard any partial debounce count.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   valid  - sample strobe; state advances only when high
//   sample - unsigned supply sample
//   th     - trip threshold (trip when sample < th)
//   hyst   - hysteresis added to th to form the release level
//   flag   - registered channel flag (high in SET and PEND_CLR)
// ---------------------------------------------------------------------------
module bod_level_fsm #(
  parameter int DATA_W   = 20,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] th,
  input  logic [DATA_W-1:0] hyst,
  output logic              flag
);

  import bod_pkg::*;

  localparam logic [BOD_CNT_W-1:0] DEB_C = BOD_CNT_W'(DEBOUNCE);

  bod_state_t           state_q, state_d;
  logic [BOD_CNT_W-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;

  logic                 trip;
  logic                 release_hit;
  logic [DATA_W:0]      release_level;
  logic [BOD_CNT_W-1:0] cnt_inc;

  // Release level is formed one bit wider so a sum past the sample range
  // makes release unreachable instead of wrapping to a small value.
  always_comb begin
    release_level = {1'b0, th} + {1'b0, hyst};
    trip          = (sample < th);
    release_hit   = ({1'b0, sample} >= release_level);
    cnt_inc       = cnt_q + 1'b1;
  end

  // Next-state logic; the flag is registered from the next state so it
  // changes on the same edge that consumes the decisive sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (valid) begin
      unique case (state_q)
        CLEAR: begin
          if (trip) begin
            if (DEB_C == 1) begin
              state_d = SET;
              cnt_d   = '0;
            end else begin
              state_d = PEND_SET;
              cnt_d   = BOD_CNT_W'(1);
            end
          end
        end
        PEND_SET: begin
          if (trip) begin
            if (cnt_inc == DEB_C) begin
              state_d = SET;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        SET: begin
          if (release_hit) begin
            if (DEB_C == 1) begin
              state_d = CLEAR;
              cnt_d   = '0;
            end else begin
              state_d = PEND_CLR;
              cnt_d   = BOD_CNT_W'(1);
            end
          end
        end
        PEND_CLR: begin
          if (release_hit) begin
            if (cnt_inc == DEB_C) begin
              state_d = CLEAR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = SET;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      endcase
    end
    flag_d = is_flag_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/bod_threshold_detector.sv
// ---------------------------------------------------------------------------
// bod_threshold_detector
// Brownout detection front end. Runs a warning and a critical level channel
// over each ADC sample and forwards a registered copy of the sample, with a
// matching strobe, to the downstream rate-of-fall stage.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   adc_valid     - one-cycle strobe qualifying adc_in
//   adc_in        - unsigned supply sample
//   warn_th       - warning trip threshold
//   crit_th       - critical trip threshold
//   hyst          - release hysteresis for both channels
//   BOD_out1      - warning flag (also set whenever critical is set)
//   BOD_out2      - critical flag
//   adc_out       - last valid sample, held between strobes
//   sample_strobe - adc_valid delayed one cycle, aligned with outputs
// ---------------------------------------------------------------------------
module bod_threshold_detector #(
  parameter int DATA_W   = 20,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_in,
  input  logic [DATA_W-1:0] warn_th,
  input  logic [DATA_W-1:0] crit_th,
  input  logic [DATA_W-1:0] hyst,
  output logic              BOD_out1,
  output logic              BOD_out2,
  output logic [DATA_W-1:0] adc_out,
  output logic              sample_strobe
);

  import bod_pkg::*;

  logic              warn_flag;
  logic              crit_flag;
  logic [DATA_W-1:0] adc_out_q, adc_out_d;
  logic              strobe_q, strobe_d;

  bod_level_fsm #(
    .DATA_W  (DATA_W),
    .DEBOUNCE(DEBOUNCE)
  ) u_warn (
    .clk   (clk),
    .rst   (rst),
    .valid (adc_valid),
    .sample(adc_in),
    .th    (warn_th),
    .hyst  (hyst),
    .flag  (warn_flag)
  );

  bod_level_fsm #(
    .DATA_W  (DATA_W),
    .DEBOUNCE(DEBOUNCE)
  ) u_crit (
    .clk   (clk),
    .rst   (rst),
    .valid (adc_valid),
    .sample(adc_in),
    .th    (crit_th),
    .hyst  (hyst),
    .flag  (crit_flag)
  );

  // Sample forwarding: capture on every strobe, hold otherwise.
  always_comb begin
    adc_out_d = adc_out_q;
    strobe_d  = adc_valid;
    if (adc_valid) begin
      adc_out_d = adc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_out_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      adc_out_q <= adc_out_d;
      strobe_q  <= strobe_d;
    end
  end

  // Critical must always imply warning, even if crit_th is set above warn_th.
  assign BOD_out1      = warn_flag | crit_flag;
  assign BOD_out2      = crit_flag;
  assign adc_out       = adc_out_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_bod_threshold_detector.sv
// ---------------------------------------------------------------------------
// tb_bod_threshold_detector
// Self-checking bench for the brownout threshold detector. A behavioural
// model tracks each channel as a flag plus a run length of consecutive
// decisive samples and predicts all outputs after every clock.
// ---------------------------------------------------------------------------
module tb_bod_threshold_detector;

  localparam int DW  = 20;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          adc_valid;
  logic [DW-1:0] adc_in;
  logic [DW-1:0] warn_th;
  logic [DW-1:0] crit_th;
  logic [DW-1:0] hyst;
  logic          BOD_out1;
  logic          BOD_out2;
  logic [DW-1:0] adc_out;
  logic          sample_strobe;

  int checks = 0;
  int failures = 0;

  // Model state: index 0 = warning channel, 1 = critical channel.
  bit            m_flag [2];
  int            m_run  [2];
  logic [DW-1:0] m_adc;
  bit            m_strobe;

  bod_threshold_detector #(.DATA_W(DW), .DEBOUNCE(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_valid    (adc_valid),
    .adc_in       (adc_in),
    .warn_th      (warn_th),
    .crit_th      (crit_th),
    .hyst         (hyst),
    .BOD_out1     (BOD_out1),
    .BOD_out2     (BOD_out2),
    .adc_out      (adc_out),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // A channel counts consecutive decisive samples toward the opposite
  // state; anything else restarts the run.
  function automatic void model_channel(input int ch, input logic [DW-1:0] s,
                                        input logic [DW-1:0] th, input logic [DW-1:0] hy);
    longint rel_level;
    bit     decisive;
    rel_level = longint'(th) + longint'(hy);
    if (!m_flag[ch]) decisive = (longint'(s) < longint'(th));
    else             decisive = (longint'(s) >= rel_level);
    if (decisive) m_run[ch]++;
    else          m_run[ch] = 0;
    if (m_run[ch] == DEB) begin
      m_flag[ch] = !m_flag[ch];
      m_run[ch]  = 0;
    end
  endfunction

  function automatic void model_reset();
    m_flag[0] = 0; m_flag[1] = 0;
    m_run[0]  = 0; m_run[1]  = 0;
    m_adc     = '0;
    m_strobe  = 0;
  endfunction

  // Drives one cycle of inputs, advances the model at the edge, then waits
  // past the edge so outputs are sampled while stable.
  task automatic step(input logic v, input logic [DW-1:0] s, input logic r);
    adc_valid = v;
    adc_in    = s;
    rst       = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_strobe = v;
      if (v) begin
        m_adc = s;
        model_channel(0, s, warn_th, hyst);
        model_channel(1, s, crit_th, hyst);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    warn_th = 20'd50000; crit_th = 20'd40000; hyst = 20'd1000;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, '0, 1'b1);
      checks++;
      if ({BOD_out1, BOD_out2, sample_strobe} !== 3'b000 || adc_out !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got o1=%0b o2=%0b st=%0b adc=%0d expected all 0",
                 BOD_out1, BOD_out2, sample_strobe, adc_out);
      end
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if ({BOD_out1, BOD_out2, sample_strobe} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_release: got o1=%0b o2=%0b st=%0b expected 000",
               BOD_out1, BOD_out2, sample_strobe);
    end
  endtask

  task automatic test_debounce_assert();
    logic [DW-1:0] seq [8];
    logic          exp1 [8];
    seq  = '{20'd45000, 20'd45000, 20'd45000, 20'd60000,
             20'd45000, 20'd45000, 20'd45000, 20'd45000};
    exp1 = '{0, 0, 0, 0, 0, 0, 0, 1};
    warn_th = 20'd50000; crit_th = 20'd40000; hyst = 20'd1000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (BOD_out1 !== exp1[i] || BOD_out2 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL debounce_assert[%0d]: got o1=%0b o2=%0b expected o1=%0b o2=0",
                 i, BOD_out1, BOD_out2, exp1[i]);
      end
      checks++;
      if (adc_out !== seq[i] || sample_strobe !== 1'b1) begin
        failures++;
        $display("[TB] FAIL forward[%0d]: got adc=%0d st=%0b expected adc=%0d st=1",
                 i, adc_out, sample_strobe, seq[i]);
      end
    end
  endtask

  task automatic test_hyst_release();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 20'd50500, 1'b0);
      checks++;
      if (BOD_out1 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hyst_hold[%0d]: got o1=%0b expected 1", i, BOD_out1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'd51000, 1'b0);
      checks++;
      if (BOD_out1 !== (i < 3)) begin
        failures++;
        $display("[TB] FAIL hyst_release[%0d]: got o1=%0b expected %0b", i, BOD_out1, i < 3);
      end
    end
  endtask

  task automatic test_crit_implies_warn();
    step(1'b0, '0, 1'b1);
    warn_th = 20'd30000; crit_th = 20'd40000; hyst = 20'd1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'd35000, 1'b0);
      checks++;
      if (BOD_out1 !== (i == 3) || BOD_out2 !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL crit_implies_warn[%0d]: got o1=%0b o2=%0b expected %0b %0b",
                 i, BOD_out1, BOD_out2, i == 3, i == 3);
      end
    end
  endtask

  task automatic test_gaps_saturation();
    int bad;
    step(1'b0, '0, 1'b1);
    warn_th = 20'd50000; crit_th = 20'd40000; hyst = 20'd1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'd45000, 1'b0);
      checks++;
      if (BOD_out1 !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL gap_assert[%0d]: got o1=%0b expected %0b", i, BOD_out1, i == 3);
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 20'd0, 1'b0);
        checks++;
        if (sample_strobe !== 1'b0 || adc_out !== 20'd45000 || BOD_out1 !== (i == 3)) begin
          failures++;
          $display("[TB] FAIL gap_hold[%0d]: got st=%0b adc=%0d o1=%0b expected 0 45000 %0b",
                   i, sample_strobe, adc_out, BOD_out1, i == 3);
        end
      end
    end
    hyst = 20'hFFFFF;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 20'hFFFFF, 1'b0);
      if (BOD_out1 !== 1'b1 || BOD_out2 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL saturated_hold: got %0d cycles with flag dropped expected 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, '0, 1'b1);
    warn_th = 20'd50000; crit_th = 20'd40000; hyst = 20'd1000;
    for (int i = 0; i < 3; i++) step(1'b1, 20'd45000, 1'b0);
    // Reset collides with a tripping strobe; reset must win.
    step(1'b1, 20'd45000, 1'b1);
    checks++;
    if (BOD_out1 !== 1'b0 || sample_strobe !== 1'b0 || adc_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_priority: got o1=%0b st=%0b adc=%0d expected 0 0 0",
               BOD_out1, sample_strobe, adc_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'd45000, 1'b0);
      checks++;
      if (BOD_out1 !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL mid_reset[%0d]: got o1=%0b expected %0b", i, BOD_out1, i == 3);
      end
    end
    // Reset while the flag is set drops it on the following edge.
    step(1'b0, '0, 1'b1);
    checks++;
    if (BOD_out1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_drop: got o1=%0b expected 0", BOD_out1);
    end
  endtask

  task automatic test_random();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        warn_th = DW'($urandom_range(40000, 60000));
        crit_th = DW'($urandom_range(20000, 50000));
        hyst    = DW'($urandom_range(0, 5000));
      end
      step(($urandom_range(0, 3) != 0), DW'($urandom_range(10000, 70000)),
           ($urandom_range(0, 399) == 0));
      checks++;
      if (BOD_out1 !== (m_flag[0] | m_flag[1]) || BOD_out2 !== m_flag[1] ||
          adc_out !== m_adc || sample_strobe !== m_strobe) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got o1=%0b o2=%0b adc=%0d st=%0b expected %0b %0b %0d %0b",
                 i, BOD_out1, BOD_out2, adc_out, sample_strobe,
                 m_flag[0] | m_flag[1], m_flag[1], m_adc, m_strobe);
      end
    end
  endtask

  initial begin
    rst = 1'b1; adc_valid = 1'b0; adc_in = '0;
    warn_th = '0; crit_th = '0; hyst = '0;
    model_reset();
    test_reset();
    test_debounce_assert();
    test_hyst_release();
    test_crit_implies_warn();
    test_gaps_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
